dm_abstract_cmd: RTL

Sequencer for RISC-V debug "Access Register" abstract commands. It accepts commands issued by the debug module's command register, checks them against hart state, drives the GPR register-file debug port, and returns read data to data0. It owns abstractcs.busy and abstractcs.cmderr and sits between the debug module register block and the core register file.

---
 rtl/dm_abstract_cmd_if.sv | 35 +++
 rtl/dm_abstract_cmd.sv | 117 +++++++++++
 2 files changed

// File: rtl/dm_abstract_cmd_if.sv
// dm_abstract_cmd_if: debug-module command, abstractcs and GPR debug-port signals
// shared between the register block/regfile (master) and the command sequencer (slave).
interface dm_abstract_cmd_if #(
    parameter int XLEN = 32
);
    logic            dm_active;
    logic            cmd_valid;
    logic [31:0]     cmd;
    logic [2:0]      cmderr_clr;
    logic            halted;
    logic [XLEN-1:0] data0;
    logic [XLEN-1:0] data0_wdata;
    logic            data0_we;
    logic [15:0]     cmd_regno;
    logic            cmd_regno_we;
    logic [4:0]      reg_addr;
    logic            reg_re;
    logic [XLEN-1:0] reg_rdata;
    logic [XLEN-1:0] reg_wdata;
    logic            reg_we;
    logic            busy;
    logic [2:0]      cmderr;

    modport master (
        output dm_active, cmd_valid, cmd, cmderr_clr, halted, data0, reg_rdata,
        input  data0_wdata, data0_we, cmd_regno, cmd_regno_we, reg_addr, reg_re,
               reg_wdata, reg_we, busy, cmderr
    );

    modport slave (
        input  dm_active, cmd_valid, cmd, cmderr_clr, halted, data0, reg_rdata,
        output data0_wdata, data0_we, cmd_regno, cmd_regno_we, reg_addr, reg_re,
               reg_wdata, reg_we, busy, cmderr
    );
endinterface

// File: rtl/dm_abstract_cmd.sv
// dm_abstract_cmd: RISC-V debug Access Register sequencer; validates commands against
// hart state, drives the GPR debug port and owns abstractcs.busy/cmderr.
module dm_abstract_cmd #(
    parameter int          XLEN     = 32,
    parameter int          NUM_GPR  = 32,
    parameter logic [15:0] GPR_BASE = 16'h1000
) (
    input logic iClk,
    input logic nRst,
    dm_abstract_cmd_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DECODE, XFER, DONE} state_t;

    // Reserved bit 23 is not latched.
    typedef struct packed {
        logic [7:0]  cmdtype;
        logic [2:0]  aarsize;
        logic        postinc;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } cmd_t;

    localparam logic [16:0] LO = {1'b0, GPR_BASE};
    localparam logic [16:0] HI = LO + 17'(NUM_GPR) - 17'd1;

    state_t     state;
    cmd_t       cmd_q;
    logic       in_range;
    logic [2:0] dec_err;
    logic [2:0] set_code;
    logic [2:0] cmderr_next;

    always_comb begin
        in_range    = {1'b0, cmd_q.regno} >= LO && {1'b0, cmd_q.regno} <= HI;
        dec_err     = (cmd_q.cmdtype != 8'd0 || cmd_q.aarsize != 3'd2 || cmd_q.postexec) ? 3'd2 :
                      !bus.halted                    ? 3'd4 :
                      (cmd_q.transfer && !in_range)  ? 3'd3 : 3'd0;
        set_code    = (state == DECODE && dec_err != 3'd0) ? dec_err :
                      (bus.cmd_valid && bus.busy)          ? 3'd1 : 3'd0;
        // Sticky: only a clean cmderr can be set, and a set beats a same-cycle clear.
        cmderr_next = (set_code != 3'd0 && bus.cmderr == 3'd0) ? set_code : bus.cmderr & ~bus.cmderr_clr;
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state            <= IDLE;
            cmd_q            <= '0;
            bus.busy         <= 1'b0;
            bus.cmderr       <= 3'd0;
            bus.data0_wdata  <= {XLEN{1'b0}};
            bus.data0_we     <= 1'b0;
            bus.cmd_regno    <= 16'd0;
            bus.cmd_regno_we <= 1'b0;
            bus.reg_addr     <= 5'd0;
            bus.reg_re       <= 1'b0;
            bus.reg_wdata    <= {XLEN{1'b0}};
            bus.reg_we       <= 1'b0;
        end else if (!bus.dm_active) begin
            state            <= IDLE;
            cmd_q            <= '0;
            bus.busy         <= 1'b0;
            bus.cmderr       <= 3'd0;
            bus.data0_wdata  <= {XLEN{1'b0}};
            bus.data0_we     <= 1'b0;
            bus.cmd_regno    <= 16'd0;
            bus.cmd_regno_we <= 1'b0;
            bus.reg_addr     <= 5'd0;
            bus.reg_re       <= 1'b0;
            bus.reg_wdata    <= {XLEN{1'b0}};
            bus.reg_we       <= 1'b0;
        end else begin
            bus.data0_we     <= 1'b0;
            bus.cmd_regno_we <= 1'b0;
            bus.reg_re       <= 1'b0;
            bus.reg_we       <= 1'b0;
            bus.cmderr       <= cmderr_next;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmderr == 3'd0) begin
                        cmd_q    <= {bus.cmd[31:24], bus.cmd[22:0]};
                        state    <= DECODE;
                        bus.busy <= 1'b1;
                    end
                end
                DECODE: begin
                    if (dec_err != 3'd0 || !cmd_q.transfer) begin
                        state            <= DONE;
                        bus.cmd_regno    <= cmd_q.regno + 16'd1;
                        bus.cmd_regno_we <= cmd_q.postinc && dec_err == 3'd0;
                    end else begin
                        state        <= XFER;
                        bus.reg_addr <= 5'(cmd_q.regno - GPR_BASE);
                        bus.reg_re   <= !cmd_q.write;
                        // x0 is hardwired; the write is accepted but never reaches the regfile.
                        bus.reg_we   <= cmd_q.write && 5'(cmd_q.regno - GPR_BASE) != 5'd0;
                        if (cmd_q.write)
                            bus.reg_wdata <= bus.data0;
                    end
                end
                XFER: begin
                    state            <= DONE;
                    bus.data0_we     <= !cmd_q.write;
                    bus.cmd_regno    <= cmd_q.regno + 16'd1;
                    bus.cmd_regno_we <= cmd_q.postinc;
                    if (!cmd_q.write)
                        bus.data0_wdata <= bus.reg_rdata;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
